mask_count_sched: RTL and testbench

- Controller and scheduler for the masked up-counter datapath, where every Nth count value is forced to zero.
- Owns the count sequence and the modulo-N mask phase, and runs a start/stop/done control handshake.
- Streams each count value to a consumer over a valid/ready interface with backpressure.
- Sits between the control register block (configuration) and the downstream sink (pattern consumer).

---
 rtl/mask_sched_pkg.sv | 20 ++
 rtl/mod_phase_ctr.sv | 37 +++
 rtl/mask_count_sched.sv | 121 ++++++++++++
 tb/tb_mask_count_sched.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mask_sched_pkg.sv
// Shared definitions for the masked up-counter scheduler.
// Holds the FSM state encoding, the datapath width defaults and the
// configuration values restored on reset.
package mask_sched_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DIV_W = 3;

  // Configuration register reset values
  localparam int   DEF_DIV   = 3;
  localparam int   DEF_LIMIT = 15;
  localparam logic DEF_CONT  = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mod_phase_ctr.sv
// Modulo-N phase counter for the mask sequence.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clr       - force the phase back to 0 (start of run or wrap of count)
//   adv       - advance the phase by one (one accepted beat)
//   div       - divisor N; the phase runs 0..N-1
//   is_zero   - phase is currently 0
module mod_phase_ctr #(
  parameter int DIV_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  input  logic [DIV_W-1:0] div,
  output logic             is_zero
);

  logic [DIV_W-1:0] r_ph;
  logic [DIV_W-1:0] w_last_ph;

  // With div = 0 this wraps to all-ones; the phase then free-runs, which is
  // harmless because the top ignores the phase when masking is disabled.
  assign w_last_ph = div - 1'b1;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_ph <= '0;
    end else if (adv) begin
      if (r_ph == w_last_ph) r_ph <= '0;
      else                   r_ph <= r_ph + 1'b1;
    end
  end

  assign is_zero = (r_ph == '0);

endmodule

// File: rtl/mask_count_sched.sv
// Controller/scheduler for the masked up-counter datapath.
// Counts 0..limit, forces every Nth value (multiples of N) to zero and
// streams each value over a valid/ready interface, with a start/stop/done
// handshake towards the control block.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   cfg_load, cfg_div,
//   cfg_limit, cfg_cont   - configuration, latched only in IDLE
//   start, stop           - run control
//   out_ready/out_valid,
//   out_data, out_masked  - stream to the consumer
//   busy, done, wrap      - status
module mask_count_sched
  import mask_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_load,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             cfg_cont,
  input  logic             start,
  input  logic             stop,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_masked,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_t           r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_limit;
  logic [DIV_W-1:0] r_div;
  logic             r_cont;
  logic             r_stop_pend;
  logic             r_wrap;

  logic w_start;
  logic w_xfer;
  logic w_last;
  logic w_stop_any;
  logic w_end_run;
  logic w_wrap_evt;
  logic w_ph_clr;
  logic w_ph_zero;
  logic w_masked;

  assign w_start    = (r_state == ST_IDLE) && start;
  assign w_xfer     = (r_state == ST_RUN) && out_ready;
  assign w_last     = (r_cnt == r_limit);
  // A stop arriving together with a transfer ends the run after that beat.
  assign w_stop_any = stop || r_stop_pend;
  assign w_end_run  = w_xfer && (w_stop_any || (w_last && !r_cont));
  assign w_wrap_evt = w_xfer && w_last && r_cont && !w_stop_any;
  // Phase restarts together with the count so masked beats stay on multiples of N.
  assign w_ph_clr   = w_start || w_wrap_evt;

  mod_phase_ctr #(
    .DIV_W (DIV_W)
  ) u_phase (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_ph_clr),
    .adv     (w_xfer),
    .div     (r_div),
    .is_zero (w_ph_zero)
  );

  assign w_masked = (r_div != '0) && w_ph_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_stop_pend <= 1'b0;
      r_wrap      <= 1'b0;
      r_div       <= DIV_W'(DEF_DIV);
      r_limit     <= WIDTH'(DEF_LIMIT);
      r_cont      <= DEF_CONT;
    end else begin
      r_wrap <= w_wrap_evt;
      case (r_state)
        ST_IDLE: begin
          // Load before start so a same-cycle load applies to this run.
          if (cfg_load) begin
            r_div   <= cfg_div;
            r_limit <= cfg_limit;
            r_cont  <= cfg_cont;
          end
          if (start) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_stop_pend <= 1'b0;
          end
        end
        ST_RUN: begin
          if (stop) r_stop_pend <= 1'b1;
          if (w_end_run)       r_state <= ST_DONE;
          else if (w_wrap_evt) r_cnt   <= '0;
          else if (w_xfer)     r_cnt   <= r_cnt + 1'b1;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid  = (r_state == ST_RUN);
  assign out_data   = w_masked ? '0 : r_cnt;
  assign out_masked = w_masked;
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign wrap       = r_wrap;

endmodule

// File: tb/tb_mask_count_sched.sv
// Directed self-checking bench for mask_count_sched.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mask_count_sched;

  localparam int WIDTH = 4;
  localparam int DIV_W = 3;

  logic             clk;
  logic             rst;
  logic             cfg_load;
  logic [DIV_W-1:0] cfg_div;
  logic [WIDTH-1:0] cfg_limit;
  logic             cfg_cont;
  logic             start;
  logic             stop;
  logic             out_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_masked;
  logic             busy;
  logic             done;
  logic             wrap;

  int n_chk;
  int n_fail;

  mask_count_sched #(
    .WIDTH (WIDTH),
    .DIV_W (DIV_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_load   (cfg_load),
    .cfg_div    (cfg_div),
    .cfg_limit  (cfg_limit),
    .cfg_cont   (cfg_cont),
    .start      (start),
    .stop       (stop),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_masked (out_masked),
    .busy       (busy),
    .done       (done),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input int dv, input int lim, input logic c);
    cfg_load  = 1'b1;
    cfg_div   = DIV_W'(dv);
    cfg_limit = WIDTH'(lim);
    cfg_cont  = c;
    tick();
    cfg_load  = 1'b0;
  endtask

  // Single pass with out_ready held high; beats k with k % dv == 0 are masked.
  task automatic go_and_check(input string tag, input int lim, input int dv);
    bit m;
    start     = 1'b1;
    out_ready = 1'b1;
    stop      = 1'b0;
    tick();
    start = 1'b0;
    for (int k = 0; k <= lim; k++) begin
      m = (dv == 0) ? 1'b0 : ((k % dv) == 0);
      check_val({tag, "_valid"}, out_valid, 1);
      check_val({tag, "_data"}, out_data, m ? 0 : k);
      check_val({tag, "_mask"}, out_masked, m);
      tick();
    end
    check_val({tag, "_done"}, done, 1);
    check_val({tag, "_valid_off"}, out_valid, 0);
    tick();
    check_val({tag, "_done_once"}, done, 0);
    check_val({tag, "_idle"}, busy, 0);
  endtask

  int          exp1 [16] = '{0, 1, 2, 0, 4, 5, 0, 7, 8, 0, 10, 11, 0, 13, 14, 0};
  logic [15:0] mask1     = 16'h9249;

  int   ecnt, pass, nwrap, last_tx;
  bit   stop_sent, rdy_t, got_done, expect_wrap, xfer_now, m3;

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst       = 1'b1;
    cfg_load  = 1'b0;
    cfg_div   = '0;
    cfg_limit = '0;
    cfg_cont  = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check_val("rst_valid", out_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_wrap", wrap, 0);
    rst = 1'b0;
    tick();

    // Scenario 1: defaults, ready always high
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    check_val("s1_busy", busy, 1);
    for (int k = 0; k < 16; k++) begin
      check_val("s1_valid", out_valid, 1);
      check_val("s1_data", out_data, exp1[k]);
      check_val("s1_mask", out_masked, mask1[k]);
      tick();
    end
    check_val("s1_done", done, 1);
    check_val("s1_valid_off", out_valid, 0);
    check_val("s1_busy_done", busy, 1);
    tick();
    check_val("s1_done_once", done, 0);
    check_val("s1_idle", busy, 0);

    // Scenario 2: masking disabled, short pass
    load_cfg(0, 5, 1'b0);
    go_and_check("s2", 5, 0);

    // Scenario 3: continuous, toggling ready, stop in second pass at 7
    cfg_load  = 1'b1;
    cfg_div   = 3'd3;
    cfg_limit = 4'd15;
    cfg_cont  = 1'b1;
    start     = 1'b1;
    tick();
    cfg_load    = 1'b0;
    start       = 1'b0;
    ecnt        = 0;
    pass        = 0;
    nwrap       = 0;
    last_tx     = -1;
    stop_sent   = 1'b0;
    rdy_t       = 1'b1;
    got_done    = 1'b0;
    expect_wrap = 1'b0;
    for (int c = 0; c < 200 && !got_done; c++) begin
      if (wrap) nwrap++;
      if (expect_wrap) check_val("s3_wrap_pulse", wrap, 1);
      expect_wrap = 1'b0;
      if (done) begin
        got_done = 1'b1;
        check_val("s3_last_tx", last_tx, 7);
        check_val("s3_pass", pass, 1);
        check_val("s3_valid_off", out_valid, 0);
      end else begin
        m3 = ((ecnt % 3) == 0);
        check_val("s3_valid", out_valid, 1);
        check_val("s3_data", out_data, m3 ? 0 : ecnt);
        check_val("s3_mask", out_masked, m3);
        out_ready = rdy_t;
        stop      = (pass == 1) && (ecnt == 7) && !stop_sent;
        if (stop) stop_sent = 1'b1;
        xfer_now = out_valid && rdy_t;
        tick();
        stop = 1'b0;
        if (xfer_now) begin
          last_tx = ecnt;
          if (ecnt == 15) begin
            ecnt        = 0;
            pass++;
            expect_wrap = 1'b1;
          end else begin
            ecnt++;
          end
        end
        rdy_t = !rdy_t;
      end
    end
    if (!got_done) check_val("s3_timeout", 0, 1);
    check_val("s3_wrap_count", nwrap, 1);
    out_ready = 1'b1;
    tick();
    check_val("s3_idle", busy, 0);

    // Scenario 4: div = 1, load/start while busy must be ignored
    load_cfg(1, 3, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_val("s4_valid", out_valid, 1);
      check_val("s4_data", out_data, 0);
      check_val("s4_mask", out_masked, 1);
      if (k == 1) begin
        cfg_load  = 1'b1;
        cfg_div   = 3'd0;
        cfg_limit = 4'd9;
        cfg_cont  = 1'b1;
        start     = 1'b1;
      end
      tick();
      cfg_load = 1'b0;
      start    = 1'b0;
    end
    check_val("s4_done", done, 1);
    tick();
    check_val("s4_idle", busy, 0);
    go_and_check("s4b", 3, 1);

    // Scenario 5: reset mid-run at cnt 9, then defaults again
    load_cfg(2, 12, 1'b0);
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    check_val("s5_cnt9", out_data, 9);
    rst = 1'b1;
    tick();
    check_val("s5_valid", out_valid, 0);
    check_val("s5_busy", busy, 0);
    check_val("s5_done", done, 0);
    rst = 1'b0;
    tick();
    check_val("s5_no_done", done, 0);
    go_and_check("s5_def", 15, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
